address_region_mapper: RTL and testbench
========================================

Name: address_region_mapper

Overview:
Table-driven, pipelined successor of the fixed-mapper address decoder. It holds NUM_REGIONS programmable windows. Each window has a match value and mask, a translation base, a window mask and flags. The MCU loads the windows into a shadow table and commits them atomically. On every clock, the block translates SNES_ADDR into ROM_ADDR, ROM_HIT, IS_SAVERAM and IS_WRITABLE, with a fixed 2-cycle latency. It sits between the SNES bus sampler and the SRAM arbiter, in the same place as the legacy mapper mux.

Parameters:
NUM_REGIONS, 8, number of windows (2..16)
IDX_W, 3, width of a region index (clog2 NUM_REGIONS)
ADDR_W, 24, SNES and ROM address width

Ports:
CLK  in  1  system clock
RST  in  1  reset; synchronous, active-high, sampled on CLK rising edge
SNES_ADDR  in  ADDR_W  requested SNES address, sampled every cycle
cfg_we  in  1  one-cycle write strobe to the shadow table
cfg_idx  in  IDX_W  region being written
cfg_field  in  3  0=MATCH 1=MASK 2=BASE 3=WMASK 4=FLAGS, 5..7 ignored
cfg_data  in  ADDR_W  field value; FLAGS uses bit0 enable, bit1 writable, bit2 saveram
cfg_commit  in  1  one-cycle strobe: shadow table -> active table
cfg_pending  out  1  shadow table differs from last commit
ROM_ADDR  out  ADDR_W  translated address
ROM_HIT  out  1  some enabled region matched
IS_SAVERAM  out  1  FLAGS.saveram of the winning region
IS_WRITABLE  out  1  FLAGS.writable of the winning region
region_idx  out  IDX_W  index of the winning region, 0 on miss

Behaviour:
- Reset:
  - Shadow and active tables are cleared to all-zero, so every region is disabled.
  - Pipeline registers are cleared.
  - All outputs are 0 on the cycle after RST is sampled high.
  - RST asserted mid-lookup discards in-flight results; no stale output appears after reset.
- Region match: hit[i] = FLAGS[i].enable & ((SNES_ADDR & MASK[i]) == (MATCH[i] & MASK[i])).
- Priority: the lowest matching index wins. Overlapping windows are legal.
- Translation: ROM_ADDR = (BASE + (SNES_ADDR & WMASK)) mod 2^ADDR_W. The sum is ADDR_W-bit unsigned and any carry out is dropped.
- Miss: ROM_HIT, IS_SAVERAM, IS_WRITABLE, ROM_ADDR and region_idx are all 0.
- Pipeline:
  - Stage 1 registers SNES_ADDR and the hit vector, evaluated against the active table.
  - Stage 2 priority-encodes, adds and registers all outputs.
  - Latency is exactly 2 CLK from SNES_ADDR to outputs, with one new result per cycle and no stalls.
- Config write: cfg_we updates only the addressed shadow field, on the same edge. The active table is untouched.
- cfg_idx >= NUM_REGIONS or cfg_field > 4: the write is ignored and cfg_pending does not change.
- Commit: on the cfg_commit edge, the whole active table is replaced by the shadow table as it stood before that edge.
  - An address sampled into stage 1 on the commit edge uses the old table.
  - The next sample uses the new table.
  - No address ever mixes old and new entries.
- cfg_pending:
  - Set by a valid cfg_we.
  - Cleared by cfg_commit.
  - If cfg_we and cfg_commit fall on the same edge, the write is excluded from the commit and cfg_pending stays 1.
- Commit with nothing pending is legal. The active table keeps the same contents.

Test Plan:
1. Reset: hold RST 2 cycles, then drive SNES_ADDR=C08000 -> all outputs 0, cfg_pending=0.
2. LoROM-style region 0: MATCH=008000, MASK=408000, BASE=000000, WMASK=007FFF, FLAGS=1, then commit. Drive 018123 -> two cycles later ROM_HIT=1, ROM_ADDR=000123, region_idx=0.
3. Priority and saveram:
   - Region 1: MATCH=700000, MASK=F08000, BASE=E00000, WMASK=001FFF, FLAGS=7.
   - Region 0 set to cover bank 70 as well.
   - Drive 701234 -> region_idx=0.
   - Disable region 0 and commit -> region_idx=1, ROM_ADDR=E01234, IS_SAVERAM=1, IS_WRITABLE=1.
4. Atomic commit: stream a new address every cycle and commit on cycle N -> results for samples before N use the old map, from N+1 the new map, with no mixed cycle.
5. Simultaneous cfg_we and cfg_commit -> cfg_pending stays 1 and the write is not visible; a second commit makes it visible. Writing idx=NUM_REGIONS is ignored.
6. Wrap-around: BASE=FFFFF0, WMASK=0000FF, address xx0020 -> ROM_ADDR=000010.

Source files
------------

// File: rtl/address_region_mapper.sv
// Table-driven SNES address translator: NUM_REGIONS programmable windows with a
// shadow/active table pair for atomic commits, and a fixed two-stage lookup pipeline.
module address_region_mapper #(
    parameter int NUM_REGIONS = 8,
    parameter int IDX_W       = 3,
    parameter int ADDR_W      = 24
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic [ADDR_W-1:0] SNES_ADDR,
    input  logic              cfg_we,
    input  logic [IDX_W-1:0]  cfg_idx,
    input  logic [2:0]        cfg_field,
    input  logic [ADDR_W-1:0] cfg_data,
    input  logic              cfg_commit,
    output logic              cfg_pending,
    output logic [ADDR_W-1:0] ROM_ADDR,
    output logic              ROM_HIT,
    output logic              IS_SAVERAM,
    output logic              IS_WRITABLE,
    output logic [IDX_W-1:0]  region_idx
);

    localparam logic [2:0] F_MATCH = 3'd0;
    localparam logic [2:0] F_MASK  = 3'd1;
    localparam logic [2:0] F_BASE  = 3'd2;
    localparam logic [2:0] F_WMASK = 3'd3;
    localparam logic [2:0] F_FLAGS = 3'd4;

    // Flags layout: bit0 enable, bit1 writable, bit2 saveram.
    logic [ADDR_W-1:0] sh_match_q  [NUM_REGIONS];
    logic [ADDR_W-1:0] sh_mask_q   [NUM_REGIONS];
    logic [ADDR_W-1:0] sh_base_q   [NUM_REGIONS];
    logic [ADDR_W-1:0] sh_wmask_q  [NUM_REGIONS];
    logic [2:0]        sh_flags_q  [NUM_REGIONS];

    logic [ADDR_W-1:0] act_match_q [NUM_REGIONS];
    logic [ADDR_W-1:0] act_mask_q  [NUM_REGIONS];
    logic [ADDR_W-1:0] act_base_q  [NUM_REGIONS];
    logic [ADDR_W-1:0] act_wmask_q [NUM_REGIONS];
    logic [2:0]        act_flags_q [NUM_REGIONS];

    // Copy of the translation fields as they were when stage 1 sampled, so a commit
    // on the sampling edge cannot leak new BASE/WMASK/FLAGS into an old-table hit.
    logic [ADDR_W-1:0] s1_base_q   [NUM_REGIONS];
    logic [ADDR_W-1:0] s1_wmask_q  [NUM_REGIONS];
    logic [1:0]        s1_flags_q  [NUM_REGIONS];

    logic                   cfg_valid;
    logic                   pending_d, pending_q;
    logic [NUM_REGIONS-1:0] hit_d, s1_hit_q;
    logic [ADDR_W-1:0]      s1_addr_q;

    logic                   win_found;
    logic [IDX_W-1:0]       win_idx;
    logic [ADDR_W-1:0]      win_base, win_wmask;
    logic [1:0]             win_flags;
    logic [ADDR_W-1:0]      rom_addr_d, rom_addr_q;
    logic                   rom_hit_q, saveram_q, writable_q;
    logic [IDX_W-1:0]       idx_q;

    assign cfg_valid = cfg_we && (int'(cfg_idx) < NUM_REGIONS) && (cfg_field <= F_FLAGS);

    // A write on the commit edge lands in the shadow only, so the table stays pending.
    always_comb begin
        pending_d = pending_q;
        if (cfg_valid) begin
            pending_d = 1'b1;
        end else if (cfg_commit) begin
            pending_d = 1'b0;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            pending_q <= 1'b0;
            for (int i = 0; i < NUM_REGIONS; i++) begin
                sh_match_q[i]  <= '0;
                sh_mask_q[i]   <= '0;
                sh_base_q[i]   <= '0;
                sh_wmask_q[i]  <= '0;
                sh_flags_q[i]  <= '0;
                act_match_q[i] <= '0;
                act_mask_q[i]  <= '0;
                act_base_q[i]  <= '0;
                act_wmask_q[i] <= '0;
                act_flags_q[i] <= '0;
            end
        end else begin
            pending_q <= pending_d;
            for (int i = 0; i < NUM_REGIONS; i++) begin
                if (cfg_valid && (cfg_idx == IDX_W'(i))) begin
                    case (cfg_field)
                        F_MATCH: sh_match_q[i] <= cfg_data;
                        F_MASK:  sh_mask_q[i]  <= cfg_data;
                        F_BASE:  sh_base_q[i]  <= cfg_data;
                        F_WMASK: sh_wmask_q[i] <= cfg_data;
                        F_FLAGS: sh_flags_q[i] <= cfg_data[2:0];
                        default: ;
                    endcase
                end
                if (cfg_commit) begin
                    act_match_q[i] <= sh_match_q[i];
                    act_mask_q[i]  <= sh_mask_q[i];
                    act_base_q[i]  <= sh_base_q[i];
                    act_wmask_q[i] <= sh_wmask_q[i];
                    act_flags_q[i] <= sh_flags_q[i];
                end
            end
        end
    end

    always_comb begin
        hit_d = '0;
        for (int i = 0; i < NUM_REGIONS; i++) begin
            hit_d[i] = act_flags_q[i][0] &&
                       ((SNES_ADDR & act_mask_q[i]) == (act_match_q[i] & act_mask_q[i]));
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            s1_addr_q <= '0;
            s1_hit_q  <= '0;
            for (int i = 0; i < NUM_REGIONS; i++) begin
                s1_base_q[i]  <= '0;
                s1_wmask_q[i] <= '0;
                s1_flags_q[i] <= '0;
            end
        end else begin
            s1_addr_q <= SNES_ADDR;
            s1_hit_q  <= hit_d;
            for (int i = 0; i < NUM_REGIONS; i++) begin
                s1_base_q[i]  <= act_base_q[i];
                s1_wmask_q[i] <= act_wmask_q[i];
                s1_flags_q[i] <= act_flags_q[i][2:1];
            end
        end
    end

    // Descending scan: the last assignment, i.e. the lowest hitting index, wins.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        win_base  = '0;
        win_wmask = '0;
        win_flags = '0;
        for (int i = NUM_REGIONS - 1; i >= 0; i--) begin
            if (s1_hit_q[i]) begin
                win_found = 1'b1;
                win_idx   = IDX_W'(i);
                win_base  = s1_base_q[i];
                win_wmask = s1_wmask_q[i];
                win_flags = s1_flags_q[i];
            end
        end
        rom_addr_d = win_found ? (win_base + (s1_addr_q & win_wmask)) : '0;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            rom_addr_q <= '0;
            rom_hit_q  <= 1'b0;
            saveram_q  <= 1'b0;
            writable_q <= 1'b0;
            idx_q      <= '0;
        end else begin
            rom_addr_q <= rom_addr_d;
            rom_hit_q  <= win_found;
            saveram_q  <= win_flags[1];
            writable_q <= win_flags[0];
            idx_q      <= win_idx;
        end
    end

    assign cfg_pending = pending_q;
    assign ROM_ADDR    = rom_addr_q;
    assign ROM_HIT     = rom_hit_q;
    assign IS_SAVERAM  = saveram_q;
    assign IS_WRITABLE = writable_q;
    assign region_idx  = idx_q;

endmodule

// File: tb/tb_address_region_mapper.sv
// Bench for address_region_mapper: a reference table model feeds an expected queue that
// is drained when each lookup emerges two clocks later; scenario tasks add spot checks.
module tb_address_region_mapper;

    localparam int NR = 6;
    localparam int IW = 3;
    localparam int AW = 24;

    logic          CLK;
    logic          RST;
    logic [AW-1:0] SNES_ADDR;
    logic          cfg_we;
    logic [IW-1:0] cfg_idx;
    logic [2:0]    cfg_field;
    logic [AW-1:0] cfg_data;
    logic          cfg_commit;
    logic          cfg_pending;
    logic [AW-1:0] ROM_ADDR;
    logic          ROM_HIT;
    logic          IS_SAVERAM;
    logic          IS_WRITABLE;
    logic [IW-1:0] region_idx;

    address_region_mapper #(.NUM_REGIONS(NR), .IDX_W(IW), .ADDR_W(AW)) dut (
        .CLK(CLK), .RST(RST), .SNES_ADDR(SNES_ADDR),
        .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_field(cfg_field), .cfg_data(cfg_data),
        .cfg_commit(cfg_commit), .cfg_pending(cfg_pending),
        .ROM_ADDR(ROM_ADDR), .ROM_HIT(ROM_HIT), .IS_SAVERAM(IS_SAVERAM),
        .IS_WRITABLE(IS_WRITABLE), .region_idx(region_idx)
    );

    typedef struct packed {
        logic [31:0]   due;
        logic [AW-1:0] addr;
        logic          hit;
        logic          sav;
        logic          wr;
        logic [IW-1:0] idx;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   vectors = 0;
    int   miscompares = 0;
    logic [31:0] cyc = 0;

    // Reference model of shadow/active tables and the pending flag.
    logic [AW-1:0] m_sh_match [NR], m_sh_mask [NR], m_sh_base [NR], m_sh_wmask [NR];
    logic [2:0]    m_sh_flags [NR];
    logic [AW-1:0] m_act_match[NR], m_act_mask[NR], m_act_base[NR], m_act_wmask[NR];
    logic [2:0]    m_act_flags[NR];
    logic          m_pend;

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;

    function automatic exp_t model_lookup(input logic [AW-1:0] a, input logic [31:0] due);
        exp_t e;
        e = '0;
        e.due = due;
        for (int i = NR - 1; i >= 0; i--) begin
            if (m_act_flags[i][0] && ((a & m_act_mask[i]) == (m_act_match[i] & m_act_mask[i]))) begin
                e.hit  = 1'b1;
                e.idx  = IW'(i);
                e.addr = m_act_base[i] + (a & m_act_wmask[i]);
                e.wr   = m_act_flags[i][1];
                e.sav  = m_act_flags[i][2];
            end
        end
        return e;
    endfunction

    // Result of each sample is due at the negedge after the edge following the sample.
    always @(negedge CLK) begin
        while (exp_q.size() > 0 && exp_q[0].due == cyc) begin
            mon_e = exp_q.pop_front();
            vectors++;
            if ({ROM_HIT, IS_SAVERAM, IS_WRITABLE, region_idx, ROM_ADDR} !==
                {mon_e.hit, mon_e.sav, mon_e.wr, mon_e.idx, mon_e.addr}) begin
                miscompares++;
                $display("FAIL lookup cyc=%0d: got hit=%b sav=%b wr=%b idx=%0d addr=%h, want hit=%b sav=%b wr=%b idx=%0d addr=%h",
                         cyc, ROM_HIT, IS_SAVERAM, IS_WRITABLE, region_idx, ROM_ADDR,
                         mon_e.hit, mon_e.sav, mon_e.wr, mon_e.idx, mon_e.addr);
            end
        end
    end

    task automatic step(input logic rst, input logic [AW-1:0] addr, input logic we,
                        input logic [IW-1:0] idx, input logic [2:0] field,
                        input logic [AW-1:0] data, input logic commit);
        exp_t e;
        RST = rst; SNES_ADDR = addr; cfg_we = we; cfg_idx = idx;
        cfg_field = field; cfg_data = data; cfg_commit = commit;
        if (rst) begin
            foreach (exp_q[j]) begin
                exp_q[j].hit = 1'b0; exp_q[j].sav = 1'b0; exp_q[j].wr = 1'b0;
                exp_q[j].idx = '0;   exp_q[j].addr = '0;
            end
            e = '0;
            e.due = cyc + 2;
        end else begin
            e = model_lookup(addr, cyc + 2);
        end
        exp_q.push_back(e);
        @(posedge CLK);
        #1;
        if (rst) begin
            m_pend = 1'b0;
            for (int i = 0; i < NR; i++) begin
                m_sh_match[i] = '0; m_sh_mask[i] = '0; m_sh_base[i] = '0; m_sh_wmask[i] = '0; m_sh_flags[i] = '0;
                m_act_match[i] = '0; m_act_mask[i] = '0; m_act_base[i] = '0; m_act_wmask[i] = '0; m_act_flags[i] = '0;
            end
        end else begin
            if (commit) begin
                m_pend = 1'b0;
                for (int i = 0; i < NR; i++) begin
                    m_act_match[i] = m_sh_match[i]; m_act_mask[i] = m_sh_mask[i];
                    m_act_base[i] = m_sh_base[i]; m_act_wmask[i] = m_sh_wmask[i];
                    m_act_flags[i] = m_sh_flags[i];
                end
            end
            if (we && (int'(idx) < NR) && (field <= 3'd4)) begin
                m_pend = 1'b1;
                case (field)
                    3'd0: m_sh_match[idx] = data;
                    3'd1: m_sh_mask[idx]  = data;
                    3'd2: m_sh_base[idx]  = data;
                    3'd3: m_sh_wmask[idx] = data;
                    default: m_sh_flags[idx] = data[2:0];
                endcase
            end
        end
    endtask

    task automatic idle(input logic [AW-1:0] addr);
        step(1'b0, addr, 1'b0, '0, 3'd0, '0, 1'b0);
    endtask

    task automatic wr(input logic [IW-1:0] idx, input logic [2:0] field, input logic [AW-1:0] data);
        step(1'b0, '0, 1'b1, idx, field, data, 1'b0);
    endtask

    task automatic commit();
        step(1'b0, '0, 1'b0, '0, 3'd0, '0, 1'b1);
    endtask

    task automatic test_reset();
        step(1'b1, 24'hC08000, 1'b0, '0, 3'd0, '0, 1'b0);
        step(1'b1, 24'hC08000, 1'b0, '0, 3'd0, '0, 1'b0);
        vectors++;
        if ({cfg_pending, ROM_HIT, IS_SAVERAM, IS_WRITABLE, region_idx, ROM_ADDR} !== '0) begin
            miscompares++;
            $display("FAIL reset_hold: got pend=%b hit=%b addr=%h idx=%0d, want all 0", cfg_pending, ROM_HIT, ROM_ADDR, region_idx);
        end
        for (int k = 0; k < 3; k++) idle(24'hC08000);
        vectors++;
        if ({cfg_pending, ROM_HIT, IS_SAVERAM, IS_WRITABLE, region_idx, ROM_ADDR} !== '0) begin
            miscompares++;
            $display("FAIL reset_after: got pend=%b hit=%b addr=%h idx=%0d, want all 0", cfg_pending, ROM_HIT, ROM_ADDR, region_idx);
        end
    endtask

    task automatic test_lorom();
        wr(3'd0, 3'd0, 24'h008000);
        wr(3'd0, 3'd1, 24'h408000);
        wr(3'd0, 3'd2, 24'h000000);
        wr(3'd0, 3'd3, 24'h007FFF);
        wr(3'd0, 3'd4, 24'h000001);
        vectors++;
        if (cfg_pending !== 1'b1) begin
            miscompares++;
            $display("FAIL lorom_pending_set: got %b want 1", cfg_pending);
        end
        commit();
        vectors++;
        if (cfg_pending !== 1'b0) begin
            miscompares++;
            $display("FAIL lorom_pending_clr: got %b want 0", cfg_pending);
        end
        idle(24'h018123);
        idle(24'h000000);
        vectors++;
        if ({ROM_HIT, region_idx, ROM_ADDR} !== {1'b1, 3'd0, 24'h000123}) begin
            miscompares++;
            $display("FAIL lorom_xlate: got hit=%b idx=%0d addr=%h want hit=1 idx=0 addr=000123", ROM_HIT, region_idx, ROM_ADDR);
        end
        idle(24'h010123);
        idle(24'h000000);
    endtask

    task automatic test_priority();
        wr(3'd1, 3'd0, 24'h700000);
        wr(3'd1, 3'd1, 24'hF08000);
        wr(3'd1, 3'd2, 24'hE00000);
        wr(3'd1, 3'd3, 24'h001FFF);
        wr(3'd1, 3'd4, 24'h000007);
        wr(3'd0, 3'd1, 24'h000000);
        commit();
        idle(24'h701234);
        idle(24'h000000);
        vectors++;
        if ({ROM_HIT, region_idx, ROM_ADDR, IS_SAVERAM} !== {1'b1, 3'd0, 24'h001234, 1'b0}) begin
            miscompares++;
            $display("FAIL prio_overlap: got hit=%b idx=%0d addr=%h sav=%b want 1/0/001234/0", ROM_HIT, region_idx, ROM_ADDR, IS_SAVERAM);
        end
        wr(3'd0, 3'd4, 24'h000000);
        commit();
        idle(24'h701234);
        idle(24'h000000);
        vectors++;
        if ({ROM_HIT, region_idx, ROM_ADDR, IS_SAVERAM, IS_WRITABLE} !== {1'b1, 3'd1, 24'hE01234, 1'b1, 1'b1}) begin
            miscompares++;
            $display("FAIL prio_saveram: got hit=%b idx=%0d addr=%h sav=%b wr=%b want 1/1/E01234/1/1",
                     ROM_HIT, region_idx, ROM_ADDR, IS_SAVERAM, IS_WRITABLE);
        end
    endtask

    task automatic test_atomic_commit();
        wr(3'd1, 3'd2, 24'h100000);
        for (int k = 0; k < 8; k++) begin
            step(1'b0, 24'h700000 + 24'(k), 1'b0, '0, 3'd0, '0, (k == 3));
            if (k == 4) begin
                vectors++;
                if (ROM_ADDR !== 24'hE00003) begin
                    miscompares++;
                    $display("FAIL atomic_old: got %h want E00003", ROM_ADDR);
                end
            end
            if (k == 5) begin
                vectors++;
                if (ROM_ADDR !== 24'h100004) begin
                    miscompares++;
                    $display("FAIL atomic_new: got %h want 100004", ROM_ADDR);
                end
            end
        end
    endtask

    task automatic test_same_edge();
        step(1'b0, 24'h000000, 1'b1, 3'd1, 3'd2, 24'h200000, 1'b1);
        vectors++;
        if (cfg_pending !== 1'b1) begin
            miscompares++;
            $display("FAIL same_edge_pending: got %b want 1", cfg_pending);
        end
        idle(24'h700010);
        idle(24'h000000);
        vectors++;
        if (ROM_ADDR !== 24'h100010) begin
            miscompares++;
            $display("FAIL same_edge_hidden: got %h want 100010", ROM_ADDR);
        end
        commit();
        idle(24'h700010);
        idle(24'h000000);
        vectors++;
        if (ROM_ADDR !== 24'h200010) begin
            miscompares++;
            $display("FAIL same_edge_second_commit: got %h want 200010", ROM_ADDR);
        end
        wr(3'(NR), 3'd2, 24'h000000);
        wr(3'd1, 3'd5, 24'hFFFFFF);
        vectors++;
        if (cfg_pending !== 1'b0) begin
            miscompares++;
            $display("FAIL invalid_write_pending: got %b want 0", cfg_pending);
        end
        commit();
        idle(24'h700010);
        idle(24'h000000);
        vectors++;
        if ({ROM_HIT, region_idx, ROM_ADDR} !== {1'b1, 3'd1, 24'h200010}) begin
            miscompares++;
            $display("FAIL empty_commit: got hit=%b idx=%0d addr=%h want 1/1/200010", ROM_HIT, region_idx, ROM_ADDR);
        end
    endtask

    task automatic test_wrap();
        wr(3'd2, 3'd0, 24'h800000);
        wr(3'd2, 3'd1, 24'h800000);
        wr(3'd2, 3'd2, 24'hFFFFF0);
        wr(3'd2, 3'd3, 24'h0000FF);
        wr(3'd2, 3'd4, 24'h000001);
        commit();
        idle(24'h810020);
        idle(24'h000000);
        vectors++;
        if ({ROM_HIT, region_idx, ROM_ADDR} !== {1'b1, 3'd2, 24'h000010}) begin
            miscompares++;
            $display("FAIL wrap: got hit=%b idx=%0d addr=%h want 1/2/000010", ROM_HIT, region_idx, ROM_ADDR);
        end
    endtask

    task automatic test_reset_midflight();
        idle(24'h810020);
        step(1'b1, 24'h810020, 1'b0, '0, 3'd0, '0, 1'b0);
        vectors++;
        if ({ROM_HIT, ROM_ADDR, region_idx} !== '0) begin
            miscompares++;
            $display("FAIL reset_inflight: got hit=%b addr=%h idx=%0d want all 0", ROM_HIT, ROM_ADDR, region_idx);
        end
        idle(24'h810020);
        idle(24'h810020);
        vectors++;
        if ({cfg_pending, ROM_HIT, ROM_ADDR} !== '0) begin
            miscompares++;
            $display("FAIL reset_table_cleared: got pend=%b hit=%b addr=%h want all 0", cfg_pending, ROM_HIT, ROM_ADDR);
        end
    endtask

    task automatic test_random();
        logic [2:0]    f;
        logic [AW-1:0] d;
        for (int k = 0; k < 60; k++) begin
            f = 3'($urandom_range(0, 5));
            case (f)
                3'd1:    d = 24'($urandom_range(0, 24'hFFFFFF)) & 24'hF08000;
                3'd4:    d = 24'($urandom_range(0, 7));
                default: d = 24'($urandom_range(0, 24'hFFFFFF));
            endcase
            step(1'b0, 24'($urandom_range(0, 24'hFFFFFF)), ($urandom_range(0, 2) == 0),
                 3'($urandom_range(0, 7)), f, d, ($urandom_range(0, 5) == 0));
            vectors++;
            if (cfg_pending !== m_pend) begin
                miscompares++;
                $display("FAIL random_pending k=%0d: got %b want %b", k, cfg_pending, m_pend);
            end
        end
    endtask

    initial begin
        test_reset();
        test_lorom();
        test_priority();
        test_atomic_commit();
        test_same_edge();
        test_wrap();
        test_reset_midflight();
        test_random();
        for (int k = 0; k < 3; k++) idle(24'h000000);
        @(negedge CLK);
        vectors++;
        if (exp_q.size() > 2) begin
            miscompares++;
            $display("FAIL drain: got %0d pending results want at most 2", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
